// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: pipeline IF stage. Owns the PC, drives the instruction
// memory word address and registers the returned word into IF/ID.
// Handles redirect > flush > stall > normal at each rising edge.
// Optional build macro FETCH_RANGE_TRAP_EN adds a sticky fetch_fault output
// that halts fetch when the PC leaves the instruction window.
module instr_fetch_stage #(
  parameter logic [31:0] IMEM_BASE  = 32'h0040_0000,
  parameter int unsigned IMEM_WORDS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
`ifdef FETCH_RANGE_TRAP_EN
  output logic        fetch_fault,
`endif
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] CNT_STEP   = XLEN'(1);
  localparam logic [XLEN-1:0] NOP_WORD   = XLEN'(0);
  localparam logic [XLEN-1:0] IMEM_LIMIT = IMEM_BASE + XLEN'(4 * IMEM_WORDS);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] fetch_word;
  logic            in_window;

  logic [XLEN-1:0] ifid_pc_d;
  logic [XLEN-1:0] ifid_pc_plus4_d;
  logic [XLEN-1:0] ifid_instr_d;
  logic            ifid_valid_d;
  logic [XLEN-1:0] fetch_count_d;
`ifdef FETCH_RANGE_TRAP_EN
  logic            fetch_fault_d;
`endif

  // The only combinational path to an output: the PC is the read address.
  assign imem_addr = pc_q;

  // Window test and the word that would enter IF/ID on a normal fetch.
  // Words outside the window always enter as a NOP, whatever memory aliases.
  always_comb begin
    pc_plus4   = pc_q + PC_STEP;
    in_window  = (pc_q >= IMEM_BASE) && (pc_q < IMEM_LIMIT);
    fetch_word = in_window ? imem_data : NOP_WORD;
  end

  // Next-state selection: redirect > (trap) > flush > stall > normal.
  always_comb begin
    pc_d            = pc_q;
    ifid_pc_d       = ifid_pc;
    ifid_pc_plus4_d = ifid_pc_plus4;
    ifid_instr_d    = ifid_instr;
    ifid_valid_d    = ifid_valid;
    fetch_count_d   = fetch_count;
`ifdef FETCH_RANGE_TRAP_EN
    fetch_fault_d   = fetch_fault;
`endif

    if (redirect_valid) begin
      // Target is forced word aligned; IF/ID is squashed.
      pc_d            = {redirect_pc[XLEN-1:2], 2'b00};
      ifid_pc_d       = '0;
      ifid_pc_plus4_d = '0;
      ifid_instr_d    = '0;
      ifid_valid_d    = 1'b0;
`ifdef FETCH_RANGE_TRAP_EN
    end else if (!in_window && fetch_fault) begin
      // Halted outside the window: only reset or a redirect gets us out.
      pc_d = pc_q;
    end else if (!in_window && (flush || !stall)) begin
      // First fetch attempt outside the window: trap, hold PC, bubble.
      fetch_fault_d   = 1'b1;
      ifid_pc_d       = '0;
      ifid_pc_plus4_d = '0;
      ifid_instr_d    = '0;
      ifid_valid_d    = 1'b0;
`endif
    end else if (flush) begin
      // Squash IF/ID; the PC still advances unless stalled.
      ifid_pc_d       = '0;
      ifid_pc_plus4_d = '0;
      ifid_instr_d    = '0;
      ifid_valid_d    = 1'b0;
      if (!stall) begin
        pc_d = pc_plus4;
      end
    end else if (!stall) begin
      // Normal fetch: capture the word, advance the PC, count it.
      pc_d            = pc_plus4;
      ifid_pc_d       = pc_q;
      ifid_pc_plus4_d = pc_plus4;
      ifid_instr_d    = fetch_word;
      ifid_valid_d    = 1'b1;
      fetch_count_d   = fetch_count + CNT_STEP;
    end
  end

  // PC and IF/ID pipeline register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= IMEM_BASE;
      ifid_pc       <= '0;
      ifid_pc_plus4 <= '0;
      ifid_instr    <= '0;
      ifid_valid    <= 1'b0;
      fetch_count   <= '0;
    end else begin
      pc_q          <= pc_d;
      ifid_pc       <= ifid_pc_d;
      ifid_pc_plus4 <= ifid_pc_plus4_d;
      ifid_instr    <= ifid_instr_d;
      ifid_valid    <= ifid_valid_d;
      fetch_count   <= fetch_count_d;
    end
  end

`ifdef FETCH_RANGE_TRAP_EN
  // Sticky fetch fault flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_fault <= 1'b0;
    end else begin
      fetch_fault <= fetch_fault_d;
    end
  end
`endif

endmodule
